// File: rtl/mac_lane_seq_pkg.sv
// Shared types and default parameters for the lane-sequential MAC.
package mac_lane_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam int unsigned DEF_NUM_LANES = 3;
    localparam int unsigned DEF_LANE_W    = 8;
    localparam int unsigned DEF_ACC_W     = 20;

    // Lane index width, never narrower than one bit.
    function automatic int unsigned idx_width(input int unsigned lanes);
        return (lanes > 1) ? $clog2(lanes) : 1;
    endfunction

endpackage

// File: rtl/mac_lane_seq_lane_sel.sv
// Combinational lane extract from a packed word; lane 0 sits in the MSBs.
module mac_lane_sel #(
    parameter int unsigned NUM_LANES = 3,
    parameter int unsigned LANE_W    = 8,
    parameter int unsigned IDX_W     = 2
) (
    input  logic [NUM_LANES*LANE_W-1:0] i_word,
    input  logic [IDX_W-1:0]            i_idx,
    output logic [LANE_W-1:0]           o_lane
);

    // Select the addressed lane; out-of-range indices yield zero.
    always_comb begin
        o_lane = '0;
        for (int unsigned i = 0; i < NUM_LANES; i++) begin
            if (32'(i_idx) == i) begin
                o_lane = i_word[(NUM_LANES-1-i)*LANE_W +: LANE_W];
            end
        end
    end

endmodule

// File: rtl/mac_lane_seq.sv
// Sequential multiply-accumulate: one lane product per clock, MSB lane first,
// with start/busy, valid/ready result handshake, chaining and sticky overflow.
module mac_lane_seq
    import mac_lane_seq_pkg::*;
#(
    parameter int unsigned NUM_LANES = DEF_NUM_LANES,
    parameter int unsigned LANE_W    = DEF_LANE_W,
    parameter int unsigned ACC_W     = DEF_ACC_W,
    parameter bit          SATURATE  = 1'b1
) (
    input  logic                        clk,
    input  logic                        rst_in,
    input  logic                        start,
    input  logic                        accum_en,
    input  logic [NUM_LANES*LANE_W-1:0] inputattr,
    input  logic [NUM_LANES*LANE_W-1:0] inputcoeff,
    output logic                        busy,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [ACC_W-1:0]            acc,
    output logic                        overflow
);

    localparam int unsigned WORD_W = NUM_LANES * LANE_W;
    localparam int unsigned IDX_W  = idx_width(NUM_LANES);
    localparam int unsigned PROD_W = 2 * LANE_W;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_LANES - 1);

    state_t              r_state;
    state_t              w_state_nxt;
    logic                w_accept;
    logic                w_last;
    logic [WORD_W-1:0]   r_attr;
    logic [WORD_W-1:0]   r_coeff;
    logic [IDX_W-1:0]    r_lane_idx;
    logic [ACC_W-1:0]    r_sum;
    logic [ACC_W-1:0]    r_acc;
    logic [ACC_W-1:0]    w_sum_nxt;
    logic                r_valid;
    logic                r_ovf;
    logic [LANE_W-1:0]   w_attr_lane;
    logic [LANE_W-1:0]   w_coeff_lane;
    logic [PROD_W-1:0]   w_prod;
    logic [ACC_W:0]      w_add;

    mac_lane_sel #(
        .NUM_LANES (NUM_LANES),
        .LANE_W    (LANE_W),
        .IDX_W     (IDX_W)
    ) u_sel_attr (
        .i_word (r_attr),
        .i_idx  (r_lane_idx),
        .o_lane (w_attr_lane)
    );

    mac_lane_sel #(
        .NUM_LANES (NUM_LANES),
        .LANE_W    (LANE_W),
        .IDX_W     (IDX_W)
    ) u_sel_coeff (
        .i_word (r_coeff),
        .i_idx  (r_lane_idx),
        .o_lane (w_coeff_lane)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst_in) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state and start acceptance (IDLE, or DONE with the result taken).
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_last      = (r_lane_idx == LAST_IDX);
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_accept    = 1'b1;
                    w_state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                if (w_last) begin
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    if (start) begin
                        w_accept    = 1'b1;
                        w_state_nxt = ST_RUN;
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Lane product and one-bit-wider add; the extra bit is the overflow carry.
    always_comb begin
        w_prod    = PROD_W'(w_attr_lane) * PROD_W'(w_coeff_lane);
        w_add     = {1'b0, r_sum} + (ACC_W+1)'(w_prod);
        w_sum_nxt = (SATURATE && w_add[ACC_W]) ? '1 : w_add[ACC_W-1:0];
    end

    // Datapath: latch words on accept, accumulate in RUN, publish on the last lane.
    always_ff @(posedge clk) begin
        if (rst_in) begin
            r_attr     <= '0;
            r_coeff    <= '0;
            r_lane_idx <= '0;
            r_sum      <= '0;
            r_acc      <= '0;
            r_valid    <= 1'b0;
            r_ovf      <= 1'b0;
        end else if (w_accept) begin
            r_attr     <= inputattr;
            r_coeff    <= inputcoeff;
            r_lane_idx <= '0;
            r_valid    <= 1'b0;
            if (!accum_en) begin
                r_sum <= '0;
                r_ovf <= 1'b0;
            end
        end else if (r_state == ST_RUN) begin
            r_sum      <= w_sum_nxt;
            r_lane_idx <= r_lane_idx + IDX_W'(1);
            if (w_add[ACC_W]) begin
                r_ovf <= 1'b1;
            end
            if (w_last) begin
                r_acc   <= w_sum_nxt;
                r_valid <= 1'b1;
            end
        end else if (r_state == ST_DONE && out_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign busy      = (r_state != ST_IDLE);
    assign out_valid = r_valid;
    assign acc       = r_acc;
    assign overflow  = r_ovf;

endmodule

// File: tb/tb_mac_lane_seq.sv
// Directed self-checking bench for mac_lane_seq: a default 20-bit saturating
// instance plus 16-bit saturating and wrapping instances sharing all inputs.
module tb_mac_lane_seq;

    logic        clk = 1'b0;
    logic        rst_in;
    logic        start;
    logic        accum_en;
    logic        out_ready;
    logic [23:0] attr;
    logic [23:0] coeff;

    logic        busy, valid, ovf;
    logic [19:0] acc;
    logic        busy_s, valid_s, ovf_s;
    logic [15:0] acc_s;
    logic        busy_w, valid_w, ovf_w;
    logic [15:0] acc_w;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    mac_lane_seq u_dut (
        .clk(clk), .rst_in(rst_in), .start(start), .accum_en(accum_en),
        .inputattr(attr), .inputcoeff(coeff), .busy(busy), .out_valid(valid),
        .out_ready(out_ready), .acc(acc), .overflow(ovf)
    );

    mac_lane_seq #(.ACC_W(16), .SATURATE(1'b1)) u_sat16 (
        .clk(clk), .rst_in(rst_in), .start(start), .accum_en(accum_en),
        .inputattr(attr), .inputcoeff(coeff), .busy(busy_s), .out_valid(valid_s),
        .out_ready(out_ready), .acc(acc_s), .overflow(ovf_s)
    );

    mac_lane_seq #(.ACC_W(16), .SATURATE(1'b0)) u_wrap16 (
        .clk(clk), .rst_in(rst_in), .start(start), .accum_en(accum_en),
        .inputattr(attr), .inputcoeff(coeff), .busy(busy_w), .out_valid(valid_w),
        .out_ready(out_ready), .acc(acc_w), .overflow(ovf_w)
    );

    typedef struct {
        logic [23:0] attr;
        logic [23:0] coeff;
        logic        en;
        logic [19:0] exp_acc;
        logic        exp_ovf;
        logic        chk16;
        logic [15:0] exp_sat16;
        logic [15:0] exp_wrap16;
        logic        exp_ovf16;
    } vec_t;

    vec_t vecs[13];

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    // Waits for out_valid, counting negedges; bounded so a dead DUT cannot hang.
    task automatic wait_valid(output int cycles);
        cycles = 0;
        do begin
            @(negedge clk);
            cycles++;
        end while (!valid && cycles < 20);
    endtask

    // One full operation with result held two extra cycles before release.
    task automatic run_vec(input vec_t v, input int idx);
        int cyc;
        @(negedge clk);
        attr = v.attr; coeff = v.coeff; accum_en = v.en; start = 1'b1; out_ready = 1'b0;
        @(negedge clk);
        start = 1'b0;
        attr = 24'($urandom); coeff = 24'($urandom); accum_en = 1'($urandom);
        check($sformatf("v%0d busy_after_start", idx), 32'(busy), 32'd1);
        wait_valid(cyc);
        check($sformatf("v%0d latency", idx), cyc, 32'd3);
        check($sformatf("v%0d acc", idx), 32'(acc), 32'(v.exp_acc));
        check($sformatf("v%0d ovf", idx), 32'(ovf), 32'(v.exp_ovf));
        if (v.chk16) begin
            check($sformatf("v%0d valid16", idx), {30'd0, valid_s, valid_w}, 32'd3);
            check($sformatf("v%0d acc_sat16", idx), 32'(acc_s), 32'(v.exp_sat16));
            check($sformatf("v%0d acc_wrap16", idx), 32'(acc_w), 32'(v.exp_wrap16));
            check($sformatf("v%0d ovf_sat16", idx), 32'(ovf_s), 32'(v.exp_ovf16));
            check($sformatf("v%0d ovf_wrap16", idx), 32'(ovf_w), 32'(v.exp_ovf16));
        end
        repeat (2) @(negedge clk);
        check($sformatf("v%0d valid_held", idx), 32'(valid), 32'd1);
        check($sformatf("v%0d acc_held", idx), 32'(acc), 32'(v.exp_acc));
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check($sformatf("v%0d valid_released", idx), {30'd0, valid, busy}, 32'd0);
        if (v.chk16) begin
            check($sformatf("v%0d busy16_released", idx), {30'd0, busy_s, busy_w}, 32'd0);
        end
        @(negedge clk);
        check($sformatf("v%0d acc_idle_hold", idx), 32'(acc), 32'(v.exp_acc));
    endtask

    initial begin
        int cyc;
        int nvalid;

        vecs[0]  = '{24'h010203, 24'h040506, 1'b0, 20'h00020, 1'b0, 1'b1, 16'h0020, 16'h0020, 1'b0};
        vecs[1]  = '{24'h010203, 24'h040506, 1'b1, 20'h00040, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0};
        vecs[2]  = '{24'h010203, 24'h040506, 1'b0, 20'h00020, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0};
        vecs[3]  = '{24'hFF0000, 24'hFF0000, 1'b0, 20'h0FE01, 1'b0, 1'b1, 16'hFE01, 16'hFE01, 1'b0};
        vecs[4]  = '{24'h000A0B, 24'h00030C, 1'b0, 20'h000A2, 1'b0, 1'b1, 16'h00A2, 16'h00A2, 1'b0};
        vecs[5]  = '{24'hFFFFFF, 24'hFFFFFF, 1'b0, 20'h2FA03, 1'b0, 1'b1, 16'hFFFF, 16'hFA03, 1'b1};
        vecs[6]  = '{24'hFFFFFF, 24'hFFFFFF, 1'b1, 20'h5F406, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0};
        vecs[7]  = '{24'hFFFFFF, 24'hFFFFFF, 1'b1, 20'h8EE09, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0};
        vecs[8]  = '{24'hFFFFFF, 24'hFFFFFF, 1'b1, 20'hBE80C, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0};
        vecs[9]  = '{24'hFFFFFF, 24'hFFFFFF, 1'b1, 20'hEE20F, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0};
        vecs[10] = '{24'hFFFFFF, 24'hFFFFFF, 1'b1, 20'hFFFFF, 1'b1, 1'b0, 16'h0000, 16'h0000, 1'b0};
        vecs[11] = '{24'h010203, 24'h040506, 1'b1, 20'hFFFFF, 1'b1, 1'b0, 16'h0000, 16'h0000, 1'b0};
        vecs[12] = '{24'h010203, 24'h040506, 1'b0, 20'h00020, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0};

        // Reset, with start asserted to show reset wins.
        rst_in = 1'b1; start = 1'b1; accum_en = 1'b0; out_ready = 1'b0;
        attr = 24'h010203; coeff = 24'h040506;
        repeat (2) @(negedge clk);
        check("rst_acc", 32'(acc), 32'd0);
        check("rst_valid", 32'(valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_ovf", 32'(ovf), 32'd0);
        rst_in = 1'b0; start = 1'b0;

        foreach (vecs[i]) run_vec(vecs[i], i);

        // Start held through RUN and through DONE without ready: both ignored.
        @(negedge clk);
        attr = 24'h010203; coeff = 24'h040506; accum_en = 1'b0; start = 1'b1;
        @(negedge clk);
        attr = 24'h020202; coeff = 24'h030303;
        nvalid = 0;
        wait_valid(cyc);
        check("hs_latency", cyc, 32'd3);
        check("hs_acc_first", 32'(acc), 32'h20);
        repeat (2) begin
            @(negedge clk);
            if (valid) nvalid++;
        end
        check("hs_done_hold_count", nvalid, 32'd2);
        check("hs_acc_still_first", 32'(acc), 32'h20);
        // Back-to-back: start with ready in DONE.
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0; start = 1'b0;
        check("hs_b2b_valid_drop", 32'(valid), 32'd0);
        check("hs_b2b_busy", 32'(busy), 32'd1);
        wait_valid(cyc);
        check("hs_b2b_latency", cyc, 32'd3);
        check("hs_b2b_acc", 32'(acc), 32'h12);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("hs_b2b_release", {30'd0, valid, busy}, 32'd0);

        // Reset in RUN cycle 2 abandons the operation and clears the sum.
        @(negedge clk);
        attr = 24'hFFFFFF; coeff = 24'hFFFFFF; accum_en = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst_in = 1'b1;
        @(negedge clk);
        rst_in = 1'b0;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_valid", 32'(valid), 32'd0);
        check("abort_acc", 32'(acc), 32'd0);
        nvalid = 0;
        repeat (4) begin
            @(negedge clk);
            if (valid || busy) nvalid++;
        end
        check("abort_no_valid", nvalid, 32'd0);
        vecs[0].en = 1'b1;
        run_vec(vecs[0], 100);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Global watchdog.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1);
    end

endmodule
